mips_io_port: RTL and testbench
===============================

// Module: mips_io_port
// PURPOSE
//  Memory-mapped GPIO bridge between the MIPS_Processor data-memory bus and board pins.
//  Latches the 32-bit PortOut on store instructions.
//  Synchronises and debounces the 8-bit PortIn, and returns both ports plus a status word on loads.
//  Sits beside data memory; the datapath muxes ReadData into the load path when IoSel=1.
// PARAMETERS
//  PORTOUT_ADDR     32'h1001_0024  word address of PortOut register (R/W)
//  PORTIN_ADDR      32'h1001_0028  word address of debounced PortIn (RO)
//  STATUS_ADDR      32'h1001_002C  word address of status (bit0 CHG sticky W1C/clear-on-read; bit1 BUSY RO)
//  IN_WIDTH         8              PortIn width
//  DEBOUNCE_CYCLES  4              consecutive stable synced cycles required; legal range >=1
// PORTS
//  clk           in   1         system clock, all state on rising edge
//  reset         in   1         asynchronous, active-low; 0 clears all state
//  MemWrite      in   1         store strobe from control unit
//  MemRead       in   1         load strobe from control unit
//  Address       in   32        ALU result (byte address, word aligned)
//  WriteData     in   32        rt data for stores
//  ReadData      out  32        combinational read data; 0 when IoSel=0
//  IoSel         out  1         combinational: Address matches one of the 3 registers
//  PortIn        in   IN_WIDTH  asynchronous external input (switches)
//  PortOut       out  32        registered output port
//  InChanged     out  1         = status CHG bit (interrupt/poll line)
// BEHAVIOUR
//  Reset (reset=0, async)
//   - PortOut, sync flops, candidate, stable, counter, CHG all 0.
//  Write path
//   - MemWrite & Address==PORTOUT_ADDR: PortOut<=WriteData at the next edge (1-cycle latency).
//   - Writes to PORTIN_ADDR are ignored.
//   - Write to STATUS_ADDR with WriteData[0]=1 clears CHG.
//  Read path (combinational)
//   - PORTOUT_ADDR returns PortOut.
//   - PORTIN_ADDR returns {24'b0, stable}.
//   - STATUS_ADDR returns {30'b0, BUSY, CHG}.
//   - Any other address returns 0.
//   - MemRead & STATUS_ADDR clears CHG at the edge (clear-on-read; this cycle still reads the old value).
//   - MemRead and MemWrite both high: write takes effect, read returns pre-write value.
//  Input debounce FSM (per-port, not per-bit)
//   - Edges 1-2: s1<=PortIn, s2<=s1 (2-FF synchroniser).
//   - s2!=candidate: candidate<=s2, cnt<=0.
//   - Else if cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1 (saturates, no wrap).
//   - Else if candidate!=stable: stable<=candidate, CHG<=1.
//   - BUSY = (candidate!=stable).
//   - Latency: clean PortIn step to stable = DEBOUNCE_CYCLES+3 edges (7 at default).
//   - Glitch of < DEBOUNCE_CYCLES synced cycles never reaches stable and never sets CHG.
//   - Input that returns to stable value before the count completes: no update, no CHG.
//  Simultaneous events
//   - CHG set and CHG clear (read or W1C) on the same edge: set wins.
//  Reset mid-operation
//   - Debounce aborts; stable=0.
//   - A PortIn value held nonzero through reset reappears DEBOUNCE_CYCLES+3 edges after release and sets CHG.
//  Width rules
//   - Address compare is on the full 32 bits; no partial decode.
//   - cnt width = $clog2(DEBOUNCE_CYCLES)+1.
// STRUCTURE
//  Package mips_io_pkg
//   - Holds the three address constants and the STATUS bit indices (CHG=0, BUSY=1).
//  Sub-module io_debouncer #(W, CYCLES)
//   - Contains synchroniser + candidate/cnt/stable.
//   - Outputs stable, busy and a 1-cycle update pulse.
//  Top level
//   - Holds decode, PortOut register, CHG flag and read mux.
// TESTING
//  1 Reset low 3 cycles, release -> PortOut=0, ReadData@STATUS=0, InChanged=0.
//  2 sw 0xDEADBEEF to PORTOUT_ADDR -> PortOut=0xDEADBEEF after 1 edge; lw from it returns 0xDEADBEEF.
//  3 PortIn 0->3 held -> PORTIN reads 0x3 exactly 7 edges later (not 6); InChanged=1; BUSY=1 meanwhile.
//  4 PortIn pulse 0x01 for 2 cycles -> stable stays 0, InChanged never asserts.
//  5 lw STATUS -> reads 0x1, next cycle 0x0; repeat with a new change landing on the read edge -> CHG stays 1.
//  6 Assert reset mid-debounce (PortIn=0x5) -> all clear asynchronously; after release PORTIN=0x5 at +7 edges.

Source files
------------

// File: rtl/mips_io_port_pkg.sv
// rtl/mips_io_port_pkg.sv - register map, status bit indices and address decode for the GPIO bridge
package mips_io_pkg;

  localparam logic [31:0] PORTOUT_ADDR = 32'h1001_0024;
  localparam logic [31:0] PORTIN_ADDR  = 32'h1001_0028;
  localparam logic [31:0] STATUS_ADDR  = 32'h1001_002C;

  localparam int STATUS_CHG_BIT  = 0;
  localparam int STATUS_BUSY_BIT = 1;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_PORTOUT,
    SEL_PORTIN,
    SEL_STATUS
  } io_sel_e;

  // Full 32-bit match only; neighbouring or aliased addresses select nothing
  function automatic io_sel_e decode_addr(input logic [31:0] addr);
    case (addr)
      PORTOUT_ADDR: return SEL_PORTOUT;
      PORTIN_ADDR:  return SEL_PORTIN;
      STATUS_ADDR:  return SEL_STATUS;
      default:      return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mips_io_port_if.sv
// rtl/mips_io_port_if.sv - data-memory bus between the MIPS datapath and the GPIO bridge
interface mips_io_port_if;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        IoSel;

  modport master (
    output MemWrite, MemRead, Address, WriteData,
    input  ReadData, IoSel
  );

  modport slave (
    input  MemWrite, MemRead, Address, WriteData,
    output ReadData, IoSel
  );
endinterface

// File: rtl/mips_io_port_debouncer.sv
// rtl/mips_io_port_debouncer.sv - 2-FF synchroniser plus whole-port debounce of an async input
module io_debouncer #(
  parameter int W      = 8,
  parameter int CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_stable,
  output logic         o_busy,
  output logic         o_update
);

  localparam int             CW   = $clog2(CYCLES) + 1;
  localparam logic [CW-1:0]  LAST = CW'(CYCLES - 1);

  logic [W-1:0]  r_s1;
  logic [W-1:0]  r_s2;
  logic [W-1:0]  r_cand;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_stable;

  logic w_differ;
  logic w_counting;
  logic w_update;

  // Classify this cycle: restart on a new value, keep counting, or commit the candidate
  always_comb begin
    w_differ   = (r_s2 != r_cand);
    w_counting = !w_differ && (r_cnt < LAST);
    w_update   = !w_differ && !(r_cnt < LAST) && (r_cand != r_stable);
  end

  // Synchroniser, candidate tracking and saturating stability counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_cand   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
    end else begin
      r_s1 <= i_din;
      r_s2 <= r_s1;
      if (w_differ) begin
        r_cand <= r_s2;
        r_cnt  <= '0;
      end else if (w_counting) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_update) begin
        r_stable <= r_cand;
      end
    end
  end

  // o_update marks the edge on which stable takes the candidate, so a flag can be set in step
  assign o_stable = r_stable;
  assign o_busy   = (r_cand != r_stable);
  assign o_update = w_update;

endmodule

// File: rtl/mips_io_port.sv
// rtl/mips_io_port.sv - memory-mapped GPIO bridge: PortOut register, debounced PortIn, status
module mips_io_port
  import mips_io_pkg::*;
#(
  parameter int IN_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  mips_io_port_if.slave       bus,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic                InChanged
);

  io_sel_e             w_sel;
  logic [IN_WIDTH-1:0] w_stable;
  logic                w_busy;
  logic                w_update;
  logic                w_chg_clr;
  logic [31:0]         w_status;

  logic [31:0]         r_port_out;
  logic                r_chg;

  io_debouncer #(
    .W      (IN_WIDTH),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk      (clk),
    .reset    (reset),
    .i_din    (PortIn),
    .o_stable (w_stable),
    .o_busy   (w_busy),
    .o_update (w_update)
  );

  // Address decode, status word and CHG clear sources (clear-on-read or write-1-to-clear)
  always_comb begin
    w_sel     = decode_addr(bus.Address);
    w_status  = '0;
    w_status[STATUS_CHG_BIT]  = r_chg;
    w_status[STATUS_BUSY_BIT] = w_busy;
    w_chg_clr = (w_sel == SEL_STATUS) &&
                (bus.MemRead || (bus.MemWrite && bus.WriteData[0]));
  end

  // Combinational read mux; reads always see the pre-edge register values
  always_comb begin
    bus.ReadData = '0;
    bus.IoSel    = (w_sel != SEL_NONE);
    case (w_sel)
      SEL_PORTOUT: bus.ReadData = r_port_out;
      SEL_PORTIN:  bus.ReadData = 32'(w_stable);
      SEL_STATUS:  bus.ReadData = w_status;
      default:     bus.ReadData = '0;
    endcase
  end

  // PortOut store register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_port_out <= '0;
    end else if (bus.MemWrite && (w_sel == SEL_PORTOUT)) begin
      r_port_out <= bus.WriteData;
    end
  end

  // Sticky change flag; a fresh change on the same edge as a clear keeps it set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_chg <= 1'b0;
    end else if (w_update) begin
      r_chg <= 1'b1;
    end else if (w_chg_clr) begin
      r_chg <= 1'b0;
    end
  end

  assign PortOut   = r_port_out;
  assign InChanged = r_chg;

endmodule

// File: tb/tb_mips_io_port.sv
// tb/tb_mips_io_port.sv - scoreboard bench for mips_io_port with a window-based debounce model
module tb_mips_io_port;
  import mips_io_pkg::*;

  localparam int C = 4;

  logic       clk;
  logic       reset;
  logic [7:0] PortIn;
  logic [31:0] PortOut;
  logic       InChanged;

  mips_io_port_if bus ();

  mips_io_port #(.IN_WIDTH(8), .DEBOUNCE_CYCLES(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .PortIn    (PortIn),
    .PortOut   (PortOut),
    .InChanged (InChanged)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        io;
    logic [31:0] po;
    logic        chg;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: stable adopts a value once C+1 consecutive synchronised samples agree
  logic [7:0]  m_s1, m_s2, m_stable;
  logic [7:0]  win[$];
  logic        m_chg;
  logic [31:0] m_po;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_stable = 0; m_chg = 0; m_po = 0;
    win = {};
    for (int i = 0; i < C + 1; i++) win.push_back(8'h00);
  endtask

  task automatic model_edge(input logic wr, rd, input logic [31:0] a, wd, input logic [7:0] pin);
    logic       all_eq;
    logic [7:0] nst;
    logic       set, clr;
    win.push_back(m_s2);
    if (win.size() > C + 1) void'(win.pop_front());
    all_eq = 1'b1;
    foreach (win[i]) if (win[i] != win[0]) all_eq = 1'b0;
    nst = all_eq ? win[0] : m_stable;
    set = (nst != m_stable);
    clr = (a == STATUS_ADDR) && (rd || (wr && wd[0]));
    if (set) m_chg = 1'b1;
    else if (clr) m_chg = 1'b0;
    if (wr && a == PORTOUT_ADDR) m_po = wd;
    m_stable = nst;
    m_s2 = m_s1;
    m_s1 = pin;
  endtask

  function automatic exp_t expect_now(input logic [31:0] a);
    exp_t e;
    logic busy;
    busy  = (win[win.size()-1] != m_stable);
    e.io  = (a == PORTOUT_ADDR) || (a == PORTIN_ADDR) || (a == STATUS_ADDR);
    e.rd  = 32'h0;
    if (a == PORTOUT_ADDR) e.rd = m_po;
    else if (a == PORTIN_ADDR) e.rd = {24'h0, m_stable};
    else if (a == STATUS_ADDR) e.rd = {30'h0, busy, m_chg};
    e.po  = m_po;
    e.chg = m_chg;
    return e;
  endfunction

  task automatic drive(input logic r, wr, rd, input logic [31:0] a, wd, input logic [7:0] pin);
    reset = r;
    bus.MemWrite = wr;
    bus.MemRead = rd;
    bus.Address = a;
    bus.WriteData = wd;
    PortIn = pin;
    if (!r) model_reset();
    q.push_back(expect_now(a));
    @(posedge clk);
    if (r) model_edge(wr, rd, a, wd, pin);
    else model_reset();
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare each cycle's outputs mid-cycle against the queued expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("ReadData",  bus.ReadData, e.rd);
      check("IoSel",     {31'h0, bus.IoSel}, {31'h0, e.io});
      check("PortOut",   PortOut, e.po);
      check("InChanged", {31'h0, InChanged}, {31'h0, e.chg});
    end
  end

  logic [31:0] addr_tab [7];

  initial begin
    logic [7:0]  pin;
    int          hold;
    logic [31:0] a;
    addr_tab[0] = PORTOUT_ADDR;
    addr_tab[1] = PORTIN_ADDR;
    addr_tab[2] = STATUS_ADDR;
    addr_tab[3] = 32'h1001_0020;
    addr_tab[4] = 32'h1001_0030;
    addr_tab[5] = 32'h0000_0024;
    addr_tab[6] = 32'h9001_0028;

    reset = 1'b0;
    bus.MemWrite = 0; bus.MemRead = 0; bus.Address = 0; bus.WriteData = 0;
    PortIn = 0;
    model_reset();
    @(posedge clk); #1;

    // Reset held three cycles, then release
    for (int i = 0; i < 3; i++) drive(0, 0, 1, STATUS_ADDR, 0, 8'h00);
    drive(1, 0, 0, STATUS_ADDR, 0, 8'h00);

    // Store then load PortOut
    drive(1, 1, 0, PORTOUT_ADDR, 32'hDEAD_BEEF, 8'h00);
    drive(1, 0, 1, PORTOUT_ADDR, 0, 8'h00);
    drive(1, 1, 0, PORTIN_ADDR, 32'h1234_5678, 8'h00);
    drive(1, 1, 1, PORTOUT_ADDR, 32'h0BAD_F00D, 8'h00);

    // Two-cycle glitch never reaches stable
    drive(1, 0, 0, PORTIN_ADDR, 0, 8'h01);
    drive(1, 0, 0, PORTIN_ADDR, 0, 8'h01);
    for (int i = 0; i < 10; i++) drive(1, 0, 0, PORTIN_ADDR, 0, 8'h00);

    // Clean step to 3, watched through PORTIN then STATUS
    for (int i = 0; i < 9; i++) drive(1, 0, 0, PORTIN_ADDR, 0, 8'h03);
    for (int i = 0; i < 3; i++) drive(1, 0, 1, STATUS_ADDR, 0, 8'h03);

    // New change while STATUS is read every cycle: one read lands on the update edge
    for (int i = 0; i < 12; i++) drive(1, 0, 1, STATUS_ADDR, 0, 8'h07);
    // Write-1-to-clear path, and bounce that returns before the count completes
    for (int i = 0; i < 3; i++) drive(1, 0, 0, STATUS_ADDR, 0, 8'h09);
    for (int i = 0; i < 10; i++) drive(1, 0, 0, STATUS_ADDR, 0, 8'h07);
    drive(1, 1, 0, STATUS_ADDR, 32'h0000_0001, 8'h07);
    drive(1, 0, 0, STATUS_ADDR, 0, 8'h07);

    // Reset during a debounce with PortIn held at 5
    for (int i = 0; i < 3; i++) drive(1, 0, 0, PORTIN_ADDR, 0, 8'h05);
    for (int i = 0; i < 2; i++) drive(0, 1, 0, PORTOUT_ADDR, 32'hFFFF_FFFF, 8'h05);
    for (int i = 0; i < 10; i++) drive(1, 0, 0, PORTIN_ADDR, 0, 8'h05);

    // Randomised traffic
    pin = 8'h00; hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        pin  = 8'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 3));
        hold = $urandom_range(1, 10);
      end
      hold--;
      a = ($urandom_range(0, 9) == 0) ? $urandom : addr_tab[$urandom_range(0, 6)];
      drive(($urandom_range(0, 99) != 0), 1'($urandom), 1'($urandom), a, $urandom, pin);
    end

    drive(1, 0, 0, 32'h0, 0, pin);
    @(negedge clk); #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
